branch_resolve_unit: RTL and testbench

// Parametrised, registered branch/jump resolution stage for JZJCoreF-class cores. It computes next PC and link value
// for INCREMENT/JAL/JALR/BRANCH, evaluates branch conditions, and trains a BHT_ENTRIES-deep 2-bit-counter history table.

---
 rtl/branch_resolve_unit.sv | 181 ++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - registered branch/jump resolution with 2-bit BHT and mispredict counter
module branch_resolve_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           mode,
  input  logic [2:0]           funct3,
  input  logic [XLEN-1:0]      imm_j,
  input  logic [XLEN-1:0]      imm_i,
  input  logic [XLEN-1:0]      imm_b,
  input  logic [XLEN-1:0]      rs1,
  input  logic [XLEN-1:0]      rs2,
  input  logic [XLEN-1:0]      pc,
  input  logic                 pred_taken,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      next_pc,
  output logic [XLEN-1:0]      link_value,
  output logic                 taken,
  output logic                 mispredict,
  output logic                 bad_funct3,
  output logic                 misaligned,
  input  logic [XLEN-1:0]      lookup_pc,
  output logic                 lookup_taken,
  output logic [CNT_WIDTH-1:0] mispredict_count
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [1:0] MODE_JAL       = 2'd0;
  localparam logic [1:0] MODE_JALR      = 2'd1;
  localparam logic [1:0] MODE_BRANCH    = 2'd2;
  localparam logic [1:0] MODE_INCREMENT = 2'd3;

  logic                 out_valid_q, out_valid_d;
  logic [XLEN-1:0]      next_pc_q, next_pc_d;
  logic [XLEN-1:0]      link_value_q, link_value_d;
  logic                 taken_q, taken_d;
  logic                 mispredict_q, mispredict_d;
  logic                 bad_funct3_q, bad_funct3_d;
  logic                 misaligned_q, misaligned_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]           bht_q [BHT_ENTRIES];
  logic [1:0]           bht_d [BHT_ENTRIES];

  logic            accept, is_branch, cond, bad_cond, res_taken;
  logic            eq, lt_s, lt_u;
  logic [XLEN-1:0] seq, jalr_sum, target;
  logic [IDX_W-1:0] upd_idx;
  logic            unused_addr_bits;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign upd_idx  = pc[2 +: IDX_W];

  always_comb begin
    eq       = (rs1 == rs2);
    lt_s     = ($signed(rs1) < $signed(rs2));
    lt_u     = (rs1 < rs2);
    cond     = 1'b0;
    bad_cond = 1'b0;
    case (funct3)
      3'b000:  cond = eq;
      3'b001:  cond = !eq;
      3'b100:  cond = lt_s;
      3'b101:  cond = !lt_s;
      3'b110:  cond = lt_u;
      3'b111:  cond = !lt_u;
      default: bad_cond = 1'b1;
    endcase
  end

  always_comb begin
    seq       = pc + XLEN'(4);
    jalr_sum  = rs1 + imm_i;
    is_branch = (mode == MODE_BRANCH);
    res_taken = 1'b0;
    target    = seq;
    case (mode)
      MODE_JAL: begin
        res_taken = 1'b1;
        target    = pc + imm_j;
      end
      MODE_JALR: begin
        res_taken = 1'b1;
        target    = {jalr_sum[XLEN-1:1], 1'b0};
      end
      MODE_BRANCH: begin
        res_taken = cond;
        target    = cond ? (pc + imm_b) : seq;
      end
      MODE_INCREMENT: begin
        res_taken = 1'b0;
        target    = seq;
      end
      default: ;
    endcase
  end

  // Output register: load on accept, drop valid once consumed without a refill.
  always_comb begin
    out_valid_d  = out_valid_q;
    next_pc_d    = next_pc_q;
    link_value_d = link_value_q;
    taken_d      = taken_q;
    mispredict_d = mispredict_q;
    bad_funct3_d = bad_funct3_q;
    misaligned_d = misaligned_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      next_pc_d    = target;
      link_value_d = seq;
      taken_d      = res_taken;
      mispredict_d = is_branch && !bad_cond && (cond != pred_taken);
      bad_funct3_d = is_branch && bad_cond;
      misaligned_d = res_taken && target[1];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    bht_d = bht_q;
    if (accept && is_branch && !bad_cond) begin
      if (cond && (bht_q[upd_idx] != 2'b11)) begin
        bht_d[upd_idx] = bht_q[upd_idx] + 2'd1;
      end else if (!cond && (bht_q[upd_idx] != 2'b00)) begin
        bht_d[upd_idx] = bht_q[upd_idx] - 2'd1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid_q && out_ready && mispredict_q && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      next_pc_q    <= '0;
      link_value_q <= '0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      bad_funct3_q <= 1'b0;
      misaligned_q <= 1'b0;
      cnt_q        <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      out_valid_q  <= out_valid_d;
      next_pc_q    <= next_pc_d;
      link_value_q <= link_value_d;
      taken_q      <= taken_d;
      mispredict_q <= mispredict_d;
      bad_funct3_q <= bad_funct3_d;
      misaligned_q <= misaligned_d;
      cnt_q        <= cnt_d;
      bht_q        <= bht_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign next_pc          = next_pc_q;
  assign link_value       = link_value_q;
  assign taken            = taken_q;
  assign mispredict       = mispredict_q;
  assign bad_funct3       = bad_funct3_q;
  assign misaligned       = misaligned_q;
  assign mispredict_count = cnt_q;
  assign lookup_taken     = bht_q[lookup_pc[2 +: IDX_W]][1];

  // Only the index field of each address reaches the table.
  assign unused_addr_bits = ^{pc, lookup_pc};
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - scoreboard bench for branch_resolve_unit
module tb_branch_resolve_unit;
  localparam logic [1:0] M_JAL = 2'd0, M_JALR = 2'd1, M_BR = 2'd2, M_INC = 2'd3;

  typedef struct packed {
    logic [31:0] npc;
    logic [31:0] link;
    logic        tk;
    logic        mp;
    logic        bf;
    logic        ma;
  } res_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [1:0]  mode = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] imm_j = '0, imm_i = '0, imm_b = '0, rs1 = '0, rs2 = '0, pc = '0;
  logic        pred_taken = 1'b0;
  logic [31:0] next_pc, link_value, lookup_pc = '0;
  logic        taken, mispredict, bad_funct3, misaligned, lookup_taken;
  logic [15:0] mispredict_count;

  res_t        exp_q[$];
  logic [15:0] exp_cnt = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clock = ~clock;

  branch_resolve_unit #(.XLEN(32), .BHT_ENTRIES(16), .CNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .funct3(funct3), .imm_j(imm_j), .imm_i(imm_i), .imm_b(imm_b),
    .rs1(rs1), .rs2(rs2), .pc(pc), .pred_taken(pred_taken),
    .out_valid(out_valid), .out_ready(out_ready), .next_pc(next_pc),
    .link_value(link_value), .taken(taken), .mispredict(mispredict),
    .bad_funct3(bad_funct3), .misaligned(misaligned), .lookup_pc(lookup_pc),
    .lookup_taken(lookup_taken), .mispredict_count(mispredict_count)
  );

  function automatic res_t model(logic [1:0] m, logic [2:0] f, logic [31:0] ij, logic [31:0] ii,
                                 logic [31:0] ib, logic [31:0] r1, logic [31:0] r2,
                                 logic [31:0] p, logic pt);
    res_t r;
    logic c;
    r      = '0;
    r.link = p + 32'd4;
    r.npc  = p + 32'd4;
    c      = 1'b0;
    if (m == M_JAL) begin
      r.tk  = 1'b1;
      r.npc = p + ij;
    end else if (m == M_JALR) begin
      r.tk  = 1'b1;
      r.npc = (r1 + ii) & 32'hFFFF_FFFE;
    end else if (m == M_BR) begin
      case (f)
        3'd0: c = (r1 == r2);
        3'd1: c = (r1 != r2);
        3'd4: c = ($signed(r1) < $signed(r2));
        3'd5: c = ($signed(r1) >= $signed(r2));
        3'd6: c = (r1 < r2);
        3'd7: c = (r1 >= r2);
        default: r.bf = 1'b1;
      endcase
      r.tk = c;
      if (c) r.npc = p + ib;
      r.mp = !r.bf && (c != pt);
    end
    r.ma = r.tk && r.npc[1];
    return r;
  endfunction

  function automatic res_t obs();
    return '{npc: next_pc, link: link_value, tk: taken, mp: mispredict, bf: bad_funct3, ma: misaligned};
  endfunction

  function automatic res_t exp_head();
    return (exp_q.size() != 0) ? exp_q[0] : res_t'('0);
  endfunction

  task automatic set_req(input logic [1:0] m, input logic [2:0] f, input logic [31:0] ij,
                         input logic [31:0] ii, input logic [31:0] ib, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] p, input logic pt);
    in_valid = 1'b1; mode = m; funct3 = f; imm_j = ij; imm_i = ii; imm_b = ib;
    rs1 = r1; rs2 = r2; pc = p; pred_taken = pt;
  endtask

  task automatic push_model();
    exp_q.push_back(model(mode, funct3, imm_j, imm_i, imm_b, rs1, rs2, pc, pred_taken));
  endtask

  task automatic pop_exp();
    res_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (e.mp) exp_cnt = exp_cnt + 16'd1;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    in_valid = 1'b0;
    reset    = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    exp_q.delete();
    exp_cnt = '0;
  endtask

  task automatic test_reset();
    do_reset();
    out_ready = 1'b1;
    n_cmp++;
    if ({out_valid, obs(), mispredict_count} !== '0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_state: valid=%b res=%h cnt=%h in_ready=%b, expected all zero and in_ready=1",
               out_valid, obs(), mispredict_count, in_ready);
    end
    for (int i = 0; i < 16; i++) begin
      lookup_pc = i * 4;
      #1;
      n_cmp++;
      if (lookup_taken !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_bht[%0d]: lookup_taken=%b expected 0", i, lookup_taken);
      end
    end
  endtask

  task automatic test_beq();
    @(negedge clock);
    set_req(M_BR, 3'b000, 32'h0, 32'h0, 32'h20, 32'd5, 32'd5, 32'h100, 1'b0);
    exp_q.push_back('{npc: 32'h120, link: 32'h104, tk: 1'b1, mp: 1'b1, bf: 1'b0, ma: 1'b0});
    @(negedge clock);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || obs() !== exp_head()) begin
      n_bad++;
      $display("FAIL beq_result: valid=%b got %h expected %h", out_valid, obs(), exp_head());
    end
    pop_exp();
    @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b0 || mispredict_count !== 16'd1) begin
      n_bad++;
      $display("FAIL beq_consume: valid=%b cnt=%0d expected valid=0 cnt=1", out_valid, mispredict_count);
    end
  endtask

  task automatic test_jalr();
    set_req(M_JALR, 3'b000, 32'h0, 32'd4, 32'h0, 32'h1003, 32'h0, 32'h200, 1'b0);
    exp_q.push_back('{npc: 32'h1006, link: 32'h204, tk: 1'b1, mp: 1'b0, bf: 1'b0, ma: 1'b1});
    @(negedge clock);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || obs() !== exp_head()) begin
      n_bad++;
      $display("FAIL jalr_result: valid=%b got %h expected %h", out_valid, obs(), exp_head());
    end
    pop_exp();
    @(negedge clock);
  endtask

  task automatic test_blt();
    set_req(M_BR, 3'b100, 32'h0, 32'h0, 32'h40, 32'hFFFF_FFFF, 32'd1, 32'h300, 1'b1);
    exp_q.push_back('{npc: 32'h340, link: 32'h304, tk: 1'b1, mp: 1'b0, bf: 1'b0, ma: 1'b0});
    @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b1 || obs() !== exp_head()) begin
      n_bad++;
      $display("FAIL blt_result: valid=%b got %h expected %h", out_valid, obs(), exp_head());
    end
    pop_exp();
    set_req(M_BR, 3'b110, 32'h0, 32'h0, 32'h40, 32'hFFFF_FFFF, 32'd1, 32'h300, 1'b1);
    exp_q.push_back('{npc: 32'h304, link: 32'h304, tk: 1'b0, mp: 1'b1, bf: 1'b0, ma: 1'b0});
    @(negedge clock);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || obs() !== exp_head()) begin
      n_bad++;
      $display("FAIL bltu_result: valid=%b got %h expected %h", out_valid, obs(), exp_head());
    end
    pop_exp();
    @(negedge clock);
    n_cmp++;
    if (mispredict_count !== exp_cnt) begin
      n_bad++;
      $display("FAIL blt_count: cnt=%0d expected %0d", mispredict_count, exp_cnt);
    end
  endtask

  task automatic test_bht();
    logic [2:0] pre;
    pre = 3'b110;
    do_reset();
    out_ready = 1'b1;
    lookup_pc = 32'h40;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        n_cmp++;
        if (out_valid !== 1'b1 || obs() !== exp_head()) begin
          n_bad++;
          $display("FAIL bht_result[%0d]: got %h expected %h", i - 1, obs(), exp_head());
        end
        pop_exp();
      end
      set_req(M_BR, 3'b000, 32'h0, 32'h0, 32'h8, 32'd3, 32'd3, 32'h40, 1'b1);
      push_model();
      #1;
      n_cmp++;
      if (lookup_taken !== pre[i]) begin
        n_bad++;
        $display("FAIL bht_lookup[%0d]: lookup_taken=%b expected %b", i, lookup_taken, pre[i]);
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || obs() !== exp_head()) begin
      n_bad++;
      $display("FAIL bht_result[2]: got %h expected %h", obs(), exp_head());
    end
    pop_exp();
    n_cmp++;
    if (lookup_taken !== 1'b1) begin
      n_bad++;
      $display("FAIL bht_saturated: lookup_taken=%b expected 1", lookup_taken);
    end
    @(negedge clock);
  endtask

  task automatic test_stall();
    res_t held;
    do_reset();
    out_ready = 1'b0;
    set_req(M_BR, 3'b010, 32'h0, 32'h0, 32'h80, 32'd7, 32'd7, 32'h44, 1'b1);
    exp_q.push_back('{npc: 32'h48, link: 32'h48, tk: 1'b0, mp: 1'b0, bf: 1'b1, ma: 1'b0});
    @(negedge clock);
    set_req(M_JAL, 3'b000, 32'h10, 32'h0, 32'h0, 32'h0, 32'h0, 32'h60, 1'b0);
    held = exp_head();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs() !== held) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: in_ready=%b valid=%b got %h expected %h", i, in_ready, out_valid, obs(), held);
      end
      @(negedge clock);
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || obs() !== held) begin
      n_bad++;
      $display("FAIL stall_release: in_ready=%b got %h expected %h", in_ready, obs(), held);
    end
    pop_exp();
    push_model();
    @(negedge clock);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || obs() !== exp_head()) begin
      n_bad++;
      $display("FAIL stall_next: got %h expected %h", obs(), exp_head());
    end
    pop_exp();
    lookup_pc = 32'h44;
    set_req(M_BR, 3'b000, 32'h0, 32'h0, 32'h10, 32'd9, 32'd9, 32'h44, 1'b1);
    push_model();
    #1;
    n_cmp++;
    if (lookup_taken !== 1'b0) begin
      n_bad++;
      $display("FAIL bad_funct3_bht_pre: lookup_taken=%b expected 0", lookup_taken);
    end
    @(negedge clock);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || obs() !== exp_head()) begin
      n_bad++;
      $display("FAIL stall_beq: got %h expected %h", obs(), exp_head());
    end
    pop_exp();
    n_cmp++;
    if (lookup_taken !== 1'b1) begin
      n_bad++;
      $display("FAIL bad_funct3_bht_post: lookup_taken=%b expected 1", lookup_taken);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) begin
        n_cmp++;
        if (out_valid !== 1'b1 || obs() !== exp_head()) begin
          n_bad++;
          $display("FAIL b2b[%0d]: valid=%b got %h expected %h", i - 1, out_valid, obs(), exp_head());
        end
        pop_exp();
      end
      if (i < 39) begin
        set_req(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                $urandom & 32'h0000_0FFE, $urandom, 32'h0, $urandom & 32'hFFFF_FFFC,
                1'($urandom_range(0, 1)));
        rs2 = ($urandom_range(0, 2) == 0) ? rs1 : $urandom;
        push_model();
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clock);
    end
    n_cmp++;
    if (out_valid !== 1'b0 || mispredict_count !== exp_cnt) begin
      n_bad++;
      $display("FAIL b2b_count: valid=%b cnt=%0d expected valid=0 cnt=%0d", out_valid, mispredict_count, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    set_req(M_BR, 3'b001, 32'h0, 32'h0, 32'h100, 32'd1, 32'd2, 32'h44, 1'b0);
    push_model();
    @(negedge clock);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || obs() !== exp_head()) begin
      n_bad++;
      $display("FAIL midrst_held: valid=%b got %h expected %h", out_valid, obs(), exp_head());
    end
    #1 reset = 1'b0;
    lookup_pc = 32'h44;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || mispredict_count !== 16'd0 || lookup_taken !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_clear: valid=%b cnt=%0d lookup=%b in_ready=%b expected 0/0/0/1",
               out_valid, mispredict_count, lookup_taken, in_ready);
    end
    exp_q.delete();
    exp_cnt = '0;
    @(negedge clock);
    reset     = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_beq();
    test_jalr();
    test_blt();
    test_bht();
    test_stall();
    test_back_to_back();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
